// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver: 3-sample majority vote per bit, LSB-first payload, optional parity, one stop bit.
// Result pulses appear (N*P) cycles after start detection, with N = 2+DATA_WIDTH+PAR_EN. There is no backpressure; each word is presented exactly once.
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0]         LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] P8       = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] P16      = PRESCALE_W'(16);
    localparam logic [PRESCALE_W-1:0] P32      = PRESCALE_W'(32);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   edge_cnt_q;
    logic [BW-1:0]           bit_cnt_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [PRESCALE_W-1:0]   p_q;
    logic                    par_en_q, par_typ_q;
    logic                    samp0_q, samp1_q, bit_q;
    logic                    par_fail_q, stp_fail_q;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    parity_error_q, parity_error_d;
    logic                    stop_error_q, stop_error_d;

    logic [PRESCALE_W-1:0]   p_sel, half, last;
    logic                    start_det, bit_end, at_s0, at_s1, at_mid, maj, exp_par;

    // Unsupported prescale values fall back to 8.
    assign p_sel     = (Prescale == P16 || Prescale == P32) ? Prescale : P8;
    assign half      = p_q >> 1;
    assign last      = p_q - ONE;
    assign bit_end   = (edge_cnt_q == last);
    assign at_s0     = (edge_cnt_q == half - ONE);
    assign at_s1     = (edge_cnt_q == half);
    assign at_mid    = (edge_cnt_q == half + ONE);
    assign maj       = (samp0_q & samp1_q) | (samp0_q & RX_IN) | (samp1_q & RX_IN);
    assign exp_par   = (^shift_q) ^ par_typ_q;
    assign start_det = (state_q == IDLE || state_q == DONE) && !RX_IN;

    // State and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= IDLE;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!RX_IN) state_d = START;
            START:   if (bit_end) state_d = bit_q ? IDLE : DATA;
            DATA:    if (bit_end && bit_cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end) state_d = DONE;
            DONE:    state_d = RX_IN ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // Results are registered on the STOP->DONE transition so they are visible during DONE.
    always_comb begin
        p_data_d       = p_data_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;
        if (state_q == STOP && bit_end) begin
            if (!par_fail_q && !stp_fail_q) begin
                p_data_d     = shift_q;
                data_valid_d = 1'b1;
            end else begin
                parity_error_d = par_fail_q;
                stop_error_d   = stp_fail_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            p_q        <= P8;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            samp0_q    <= 1'b0;
            samp1_q    <= 1'b0;
            bit_q      <= 1'b0;
            par_fail_q <= 1'b0;
            stp_fail_q <= 1'b0;
        end else if (state_q == IDLE || state_q == DONE) begin
            // The detection cycle itself is edge 0 of the start bit.
            edge_cnt_q <= start_det ? ONE : '0;
            bit_cnt_q  <= '0;
            par_fail_q <= 1'b0;
            stp_fail_q <= 1'b0;
            if (start_det) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                p_q       <= p_sel;
            end
        end else begin
            edge_cnt_q <= bit_end ? '0 : edge_cnt_q + ONE;
            if (at_s0) samp0_q <= RX_IN;
            if (at_s1) samp1_q <= RX_IN;
            if (at_mid) begin
                case (state_q)
                    START:   bit_q <= maj;
                    DATA:    shift_q[bit_cnt_q] <= maj;
                    PARITY:  if (maj != exp_par) par_fail_q <= 1'b1;
                    STOP:    if (!maj) stp_fail_q <= 1'b1;
                    default: ;
                endcase
            end
            if (state_q == DATA && bit_end) bit_cnt_q <= bit_cnt_q + BW'(1);
        end
    end

    assign P_DATA       = p_data_q;
    assign data_valid   = data_valid_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: drives frames on RX_IN and logs every output pulse with its cycle number.
module tb_uart_rx_deserializer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       data_valid, parity_error, stop_error;

    uart_rx_deserializer #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .Prescale     (Prescale),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       v;
        logic       pe;
        logic       se;
        logic [7:0] d;
    } ev_t;
    ev_t pq[$];

    // Every cycle with any pulse high is logged, so a stretched pulse shows up as an extra entry.
    always @(negedge CLK)
        if (data_valid || parity_error || stop_error)
            pq.push_back('{cyc, data_valid, parity_error, stop_error, P_DATA});

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
    endtask

    // spike >= 0 inverts RX_IN for the single cycle at edge P/2 of data bit 'spike'.
    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb,
                              input int p, input int spike, output int s);
        logic bits [0:10];
        int   nb;
        logic v;
        nb = 10 + (PAR_EN ? 1 : 0);
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = d[k];
        bits[9] = PAR_EN ? pb : sb;
        bits[10] = sb;
        s = 0;
        for (int b = 0; b < nb; b++) begin
            for (int e = 0; e < p; e++) begin
                @(negedge CLK);
                if (b == 0 && e == 0) s = cyc;
                v = bits[b];
                if (b == spike + 1 && spike >= 0 && e == p / 2) v = ~v;
                RX_IN = v;
            end
        end
    endtask

    task automatic expect_pulse(input string tag, input int exp_n, input int ecyc,
                                input logic ev, input logic epe, input logic ese,
                                input logic [7:0] ed);
        ev_t e;
        chk({tag, "_npulse"}, pq.size(), exp_n);
        if (pq.size() > 0) begin
            e = pq.pop_front();
            chk({tag, "_cycle"}, e.cyc, ecyc);
            chk({tag, "_valid"}, e.v, ev);
            chk({tag, "_perr"}, e.pe, epe);
            chk({tag, "_serr"}, e.se, ese);
            chk({tag, "_pdata"}, e.d, ed);
        end
    endtask

    initial begin
        int s, s2;
        logic [7:0] d55;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_pdata", P_DATA, 8'h00);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_perr", parity_error, 1'b0);
        chk("rst_serr", stop_error, 1'b0);
        RST = 1'b1;
        idle(4);

        // Baseline, P=8, no parity: pulse at 10*8 = 80
        PAR_EN = 1'b0; Prescale = 6'd8;
        send_frame(8'hA5, 1'b0, 1'b1, 8, -1, s);
        idle(6);
        expect_pulse("base", 1, s + 80, 1'b1, 1'b0, 1'b0, 8'hA5);

        // Even parity, good then bad: pulse at 11*8 = 88
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, 8, -1, s);
        idle(6);
        expect_pulse("even_ok", 1, s + 88, 1'b1, 1'b0, 1'b0, 8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1, 8, -1, s);
        idle(6);
        expect_pulse("even_bad", 1, s + 88, 1'b0, 1'b1, 1'b0, 8'h5A);

        // Odd parity correct, stop bit 0, P=16: pulse at 11*16 = 176
        PAR_TYP = 1'b1; Prescale = 6'd16;
        send_frame(8'h0F, 1'b1, 1'b0, 16, -1, s);
        idle(20);
        expect_pulse("stop_err", 1, s + 176, 1'b0, 1'b0, 1'b1, 8'h5A);

        // Start glitch of 2 cycles, then a real frame
        PAR_EN = 1'b0; Prescale = 6'd8;
        @(negedge CLK); RX_IN = 1'b0;
        @(negedge CLK); RX_IN = 1'b0;
        idle(12);
        chk("glitch_npulse", pq.size(), 0);
        send_frame(8'h3C, 1'b0, 1'b1, 8, -1, s);
        idle(6);
        expect_pulse("after_glitch", 1, s + 80, 1'b1, 1'b0, 1'b0, 8'h3C);

        // Back-to-back, P=32, zero idle cycles between frames
        Prescale = 6'd32;
        send_frame(8'h01, 1'b0, 1'b1, 32, -1, s);
        send_frame(8'hFE, 1'b0, 1'b1, 32, -1, s2);
        idle(40);
        chk("b2b_gap", s2 - s, 320);
        expect_pulse("b2b_first", 2, s + 320, 1'b1, 1'b0, 1'b0, 8'h01);
        expect_pulse("b2b_second", 1, s + 640, 1'b1, 1'b0, 1'b0, 8'hFE);

        // Reset in the middle of data bit 3
        Prescale = 6'd8;
        d55 = 8'h55;
        for (int c = 0; c < 36; c++) begin
            @(negedge CLK);
            RX_IN = (c < 8) ? 1'b0 : d55[c/8 - 1];
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("midrst_pdata", P_DATA, 8'h00);
        chk("midrst_valid", data_valid, 1'b0);
        RX_IN = 1'b1;
        idle(3);
        RST = 1'b1;
        idle(60);
        chk("midrst_npulse", pq.size(), 0);

        // Fresh frame with a one-cycle spike at the centre of data bit 0
        send_frame(8'h81, 1'b0, 1'b1, 8, 0, s);
        idle(6);
        expect_pulse("spike", 1, s + 80, 1'b1, 1'b0, 1'b0, 8'h81);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Receive-side counterpart of the team's LSB-first, idle-high serial transmit path.
- Oversamples RX_IN and detects the start bit.
- Majority-votes each bit, then shifts DATA_WIDTH bits in LSB-first, with an optional parity bit and one stop bit.
- Presents the parallel word with a 1-cycle valid pulse, and reports parity and stop errors to the system controller.

Parameters:
DATA_WIDTH, 8, frame payload width in bits
PRESCALE_W, 6, width of Prescale input

Ports:
CLK  input  1  clock
RST  input  1  reset, asynchronous, active-low
RX_IN  input  1  serial line, idle high
PAR_EN  input  1  1 = frame carries parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
Prescale  input  PRESCALE_W  CLK cycles per bit; legal values 8, 16, 32
P_DATA  output  DATA_WIDTH  last correctly received word
data_valid  output  1  1-cycle pulse, P_DATA updated
parity_error  output  1  1-cycle pulse, bad parity
stop_error  output  1  1-cycle pulse, stop bit sampled 0

Behaviour:
- Reset (RST low, async):
  - FSM=IDLE; edge and bit counters 0; shift register 0.
  - P_DATA=0; data_valid, parity_error, stop_error all 0.
  - Reset mid-frame aborts the frame; no pulses are generated.
- Config latch: PAR_EN, PAR_TYP and Prescale are sampled at start detection and held for the whole frame. A Prescale value other than 8/16/32 is treated as 8.
- Timing origin: cycle 0 = first rising CLK edge in IDLE with RX_IN==0. That cycle is edge_cnt=0 of the start bit.
- Bit timing:
  - edge_cnt runs 0..P-1 per bit (P = latched prescale), then wraps to 0 and bit_cnt increments.
  - RX_IN is sampled at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the 3 samples, resolved at edge_cnt = P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE -> START: on RX_IN==0.
  - START: at edge_cnt=P-1, majority 0 -> DATA; majority 1 (glitch) -> IDLE, no outputs.
  - DATA: bit k (k = 0..DATA_WIDTH-1) goes to shift[k], LSB first. After bit DATA_WIDTH-1 ends: -> PARITY if PAR_EN, else -> STOP.
  - PARITY: expected bit = XOR(shift) for even, ~XOR(shift) for odd. A mismatch sets an internal par_fail flag. -> STOP at bit end.
  - STOP: majority 0 sets an internal stp_fail flag. -> DONE at bit end.
  - DONE (1 cycle): outputs are driven per the next bullet. Then -> START if RX_IN==0 (that cycle counts as edge_cnt=0), else -> IDLE.
- DONE outputs:
  - No fail flags: P_DATA <= shift, data_valid=1.
  - Any fail: P_DATA unchanged, data_valid=0. parity_error=par_fail, stop_error=stp_fail; both may assert together.
  - All pulses are exactly 1 cycle; flags clear on leaving DONE.
- Latency: pulses are high in cycle N*P, where N = 2+DATA_WIDTH+PAR_EN.
- RX_IN changes outside the sample window are ignored. RX_IN is used directly; synchronisation is external.
- Back-to-back frames: the minimum gap is 0 idle cycles after DONE; no frame is lost.

Test Plan:
- Baseline frame: P=8, PAR_EN=0; send start, data 0xA5, stop=1 -> data_valid=1 at cycle 80 only, P_DATA=0xA5, both error outputs 0.
- Even parity: P=8, PAR_EN=1, PAR_TYP=0; send 0x5A with parity 0 -> valid at cycle 88, P_DATA=0x5A. Resend with parity 1 -> parity_error=1 at cycle 88, data_valid=0, P_DATA stays 0x5A.
- Stop error and odd parity: P=16, PAR_EN=1, PAR_TYP=1; send 0x0F, parity 1, stop 0 -> stop_error=1 at cycle 176, parity_error=0, P_DATA unchanged.
- Start glitch rejection: P=8; RX_IN low for 2 cycles (cycles 0-1), then high -> FSM returns to IDLE after cycle 7, no pulses. A following valid frame of 0x3C is received correctly.
- Back-to-back frames: P=32, PAR_EN=0; frames 0x01 then 0xFE with 0 idle cycles -> two data_valid pulses 320 cycles apart, P_DATA=0x01 then 0xFE.
- Reset mid-frame and noise tolerance:
  - RST low during DATA bit 3 -> all outputs 0 immediately; FSM in IDLE after release. A new 0x81 frame is received correctly.
  - A single-cycle inverted spike at edge_cnt=P/2 of a data bit is corrected by the majority vote.
